instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential RV32I instruction encoder and program writer: accepts decoded-form instruction requests (class, registers, funct3, sub bit, immediate) over a valid/ready handshake, packs them into 32-bit instruction words, and writes them to consecutive instruction-memory word addresses through a write handshake. It is the inverse of the control-path decoding. It sits between the testbench/boot loader and instruction memory and produces exactly the opcode classes the main decoder consumes.

## Interface
- DATA_WIDTH, 32, instruction/immediate width
- ADDR_WIDTH, 32, memory address width
- BASE_ADDR, 0, first write address after reset/prog_start
- MAX_INSTRS, 256, words written before `full`
- clk  in  1  clock; the block uses a single clock
- rst  in  1  reset; synchronous, active-high
- prog_start  in  1  restart program at BASE_ADDR, clear count/err
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_op  in  3  0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5-7 illegal
- req_funct3  in  3  funct3 field
- req_sub  in  1  instr[30] (SUB/SRA/SRAI)
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_imm  in  DATA_WIDTH  signed immediate (byte offset for BRANCH)
- mem_we  out  1  write request
- mem_ready  in  1  memory accepts write when mem_we&mem_ready
- mem_addr  out  ADDR_WIDTH  word-aligned byte address
- mem_wdata  out  32  encoded instruction
- count  out  $clog2(MAX_INSTRS+1)  words written
- full  out  1  count==MAX_INSTRS
- err  out  1  sticky: illegal op or immediate out of range

## Operation
- Opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
- R: funct7={0,req_sub,00000}. I-ALU/LOAD: imm[11:0]→[31:20]; I-ALU with funct3=101 forces bit30=req_sub. STORE: imm[11:5]→[31:25], imm[4:0]→[11:7]. BRANCH: imm[12]→31, imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→7. Unused fields zero.
- One-entry output stage. req_ready = !rst & !prog_start & !full_next & (!stage_valid | mem_ready). Accepted request is encoded and registered into the stage.
- Legal request: stage_valid=1, mem_we=1 next cycle. On mem_we&mem_ready: mem_addr += 4, count += 1; stage refilled the same cycle if a new request is accepted.
- Illegal request: accepted, nothing written, addr/count unchanged, err set.
- full_next: accounts for a stage entry in flight; no more than MAX_INSTRS words ever written. mem_addr wraps modulo 2^ADDR_WIDTH.
- prog_start: stage discarded (mem_we low next cycle), mem_addr=BASE_ADDR, count=0, err=0; takes priority over simultaneous req_valid and mem_ready.

## Timing
- Reset values: req_ready=0 during rst, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0.
- Latency: accept at edge N → mem_we high after edge N (cycle N+1). Throughput 1 word/cycle with mem_ready held high.
- While mem_we&!mem_ready: mem_addr, mem_wdata, mem_we stable; req_ready=0.
- err asserts the cycle after the offending accept; stays until rst/prog_start.
- Reset mid-write: write abandoned, no count update.

## Configuration
- ENCODER_RANGE_CHECK_EN defined: I/LOAD/STORE imm outside −2048..2047, or BRANCH imm outside −4096..4094 or odd → treated as illegal (err, no write).
- Undefined: immediates silently truncated to field bits; only req_op 5-7 sets err.

## Structure
- Package instr_enc_pkg: req_op enum, the five opcode constants, immediate range constants.
- Sub-module instr_pack: combinational field packer (op/fields → word plus legal flag); instr_encoder holds handshake, stage, address/count logic.

## Test plan
- ADDI x1,x0,5 (op1,f3=0,rd1,imm5), mem_ready=1 → one write, addr 0x0, wdata 0x00500093, count=1.
- Back-to-back ADD x3,x1,x2 then SUB x3,x1,x2 → writes 0x002081B3 @0x0, 0x402081B3 @0x4 in consecutive cycles.
- SW x2,8(x1) then BEQ x1,x2,−4 → 0x0020A423, 0xFE208EE3; mem_ready low 3 cycles on second → outputs stable, req_ready=0.
- req_op=6, then ADDI imm=2048 with macro → err=1, no mem_we, mem_addr stays 0x0; prog_start clears err.
- MAX_INSTRS=4, stream 6 requests → 4 writes (0x0..0xC), full=1, req_ready=0; prog_start → addr 0x0, count 0.
- prog_start coincident with req_valid and pending write → request not accepted, mem_we low next cycle, count=0.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// ENCODER_RANGE_CHECK_EN (optional) enables immediate range checking in instr_pack.
package instr_enc_pkg;

  // Request classes; encodings 5..7 are illegal
  typedef enum logic [2:0] {
    ReqOpR      = 3'd0,
    ReqOpIAlu   = 3'd1,
    ReqOpLoad   = 3'd2,
    ReqOpStore  = 3'd3,
    ReqOpBranch = 3'd4
  } req_op_e;

  localparam logic [6:0] OpcodeR      = 7'b0110011;
  localparam logic [6:0] OpcodeIAlu   = 7'b0010011;
  localparam logic [6:0] OpcodeLoad   = 7'b0000011;
  localparam logic [6:0] OpcodeStore  = 7'b0100011;
  localparam logic [6:0] OpcodeBranch = 7'b1100011;

  // 12-bit I/S immediates and 13-bit B offsets
  localparam int ImmIMin = -2048;
  localparam int ImmIMax = 2047;
  localparam int ImmBMin = -4096;
  localparam int ImmBMax = 4094;

endpackage

// File: rtl/instr_encoder_if.sv
// Request and memory-write handshake bundle for instr_encoder.
// master: requester / memory side; slave: the encoder.
interface instr_encoder_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_op;
  logic [2:0]            req_funct3;
  logic                  req_sub;
  logic [4:0]            req_rd;
  logic [4:0]            req_rs1;
  logic [4:0]            req_rs2;
  logic [DATA_WIDTH-1:0] req_imm;

  logic                  mem_we;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output req_valid, req_op, req_funct3, req_sub, req_rd, req_rs1, req_rs2, req_imm,
    output mem_ready,
    input  req_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_op, req_funct3, req_sub, req_rd, req_rs1, req_rs2, req_imm,
    input  mem_ready,
    output req_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: request fields -> 32-bit word plus legal flag.
// ENCODER_RANGE_CHECK_EN: out-of-range or odd-branch immediates are flagged illegal;
// otherwise immediates are truncated to their field bits.
module instr_pack
  import instr_enc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  sub,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic [31:0]           word,
  output logic                  legal
);

  logic op_legal;
  logic imm_legal;

  // Field placement per instruction class
  always_comb begin
    word     = '0;
    op_legal = 1'b1;
    case (op)
      ReqOpR: begin
        word = {1'b0, sub, 5'b0, rs2, rs1, funct3, rd, OpcodeR};
      end
      ReqOpIAlu: begin
        word = {imm[11:0], rs1, funct3, rd, OpcodeIAlu};
        // SRLI/SRAI select via bit 30 regardless of the immediate
        if (funct3 == 3'b101) begin
          word[30] = sub;
        end
      end
      ReqOpLoad: begin
        word = {imm[11:0], rs1, funct3, rd, OpcodeLoad};
      end
      ReqOpStore: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OpcodeStore};
      end
      ReqOpBranch: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OpcodeBranch};
      end
      default: begin
        op_legal = 1'b0;
      end
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  logic signed [DATA_WIDTH-1:0] simm;
  assign simm = $signed(imm);

  // Immediate must fit the signed field of its class
  always_comb begin
    imm_legal = 1'b1;
    case (op)
      ReqOpIAlu, ReqOpLoad, ReqOpStore: begin
        imm_legal = (simm >= $signed(DATA_WIDTH'(ImmIMin))) &&
                    (simm <= $signed(DATA_WIDTH'(ImmIMax)));
      end
      ReqOpBranch: begin
        imm_legal = (simm >= $signed(DATA_WIDTH'(ImmBMin))) &&
                    (simm <= $signed(DATA_WIDTH'(ImmBMax))) && !imm[0];
      end
      default: begin
        imm_legal = 1'b1;
      end
    endcase
  end
`else
  // Upper immediate bits are simply dropped
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[DATA_WIDTH-1:13];
  assign imm_legal     = 1'b1;
`endif

  assign legal = op_legal & imm_legal;

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I encoder / program writer: accepts decoded requests, packs them and
// writes them to consecutive word addresses through a one-entry output stage.
// ENCODER_RANGE_CHECK_EN (optional) makes out-of-range immediates illegal (see instr_pack).
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           MAX_INSTRS = 256,
  localparam int unsigned          CountW     = $clog2(MAX_INSTRS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_start,
  instr_encoder_if.slave    bus,
  output logic [CountW-1:0] count,
  output logic              full,
  output logic              err
);

  localparam logic [CountW-1:0] MaxCount = CountW'(MAX_INSTRS);

  logic [31:0]           pack_word;
  logic                  pack_legal;

  logic                  stage_valid_q, stage_valid_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CountW-1:0]     count_q, count_d;
  logic                  err_q, err_d;

  logic [CountW:0]       committed;
  logic                  full_next;
  logic                  write_fire;
  logic                  accept;

  instr_pack #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pack (
    .op     (bus.req_op),
    .funct3 (bus.req_funct3),
    .sub    (bus.req_sub),
    .rd     (bus.req_rd),
    .rs1    (bus.req_rs1),
    .rs2    (bus.req_rs2),
    .imm    (bus.req_imm),
    .word   (pack_word),
    .legal  (pack_legal)
  );

  // Words written plus the one waiting in the stage; never let this exceed MAX_INSTRS
  assign committed  = {1'b0, count_q} + {{CountW{1'b0}}, stage_valid_q};
  assign full_next  = (committed >= {1'b0, MaxCount});
  assign write_fire = stage_valid_q & bus.mem_ready;

  assign bus.req_ready = !rst && !prog_start && !full_next && (!stage_valid_q || bus.mem_ready);
  assign accept        = bus.req_valid & bus.req_ready;

  // Next-state: drain stage, refill on accept, prog_start overrides everything
  always_comb begin
    stage_valid_d = stage_valid_q;
    wdata_d       = wdata_q;
    addr_d        = addr_q;
    count_d       = count_q;
    err_d         = err_q;

    if (write_fire) begin
      stage_valid_d = 1'b0;
      addr_d        = addr_q + ADDR_WIDTH'(4);
      count_d       = count_q + CountW'(1);
    end

    if (accept) begin
      if (pack_legal) begin
        stage_valid_d = 1'b1;
        wdata_d       = pack_word;
      end else begin
        err_d = 1'b1;
      end
    end

    if (prog_start) begin
      stage_valid_d = 1'b0;
      addr_d        = BASE_ADDR;
      count_d       = '0;
      err_d         = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      wdata_q       <= '0;
      addr_q        <= BASE_ADDR;
      count_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      wdata_q       <= wdata_d;
      addr_q        <= addr_d;
      count_q       <= count_d;
      err_q         <= err_d;
    end
  end

  assign bus.mem_we    = stage_valid_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign count         = count_q;
  assign full          = (count_q == MaxCount);
  assign err           = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed instruction words.
module tb_instr_encoder;

  localparam int unsigned MAX = 4;
  localparam int unsigned CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_start = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          err;

  instr_encoder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  instr_encoder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .BASE_ADDR  (32'h0),
    .MAX_INSTRS (MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_start (prog_start),
    .bus        (bus),
    .count      (count),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the field rules, using plain arithmetic
  function automatic logic [31:0] model_word(input int unsigned op, input int unsigned f3,
                                             input int unsigned sub, input int unsigned rd,
                                             input int unsigned rs1, input int unsigned rs2,
                                             input int imm);
    int unsigned ui;
    int unsigned b;
    int unsigned w;
    ui = imm;
    b  = ui % 8192;
    w  = 0;
    case (op)
      0: w = (sub << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      1: begin
        w = ((ui % 4096) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
        if (f3 == 5) w = (w & ~32'h4000_0000) | (sub << 30);
      end
      2: w = ((ui % 4096) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
      3: w = (((ui % 4096) / 32) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
             ((ui % 32) << 7) | 32'h23;
      4: w = ((b / 4096) << 31) | (((b / 32) % 64) << 25) | (rs2 << 20) | (rs1 << 15) |
             (f3 << 12) | (((b / 2) % 16) << 8) | (((b / 2048) % 2) << 7) | 32'h63;
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic bit model_legal(input int unsigned op, input int imm);
    if (op > 4) return 1'b0;
`ifdef ENCODER_RANGE_CHECK_EN
    if (op >= 1 && op <= 3) return (imm >= -2048) && (imm <= 2047);
    if (op == 4) return (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
`endif
    return 1'b1;
  endfunction

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] c;
  } wr_t;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr  = 32'h0;
  int          exp_count = 0;
  bit          exp_err   = 1'b0;
  wr_t         wlog[$];
  int          cyc = 0;

  // Compare present outputs against the model, then advance the model to the next edge
  always @(negedge clk) begin
    bit exp_rdy;
    cyc++;
    chk("mem_we", {31'b0, bus.mem_we}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk("mem_addr", bus.mem_addr, exp_addr);
      chk("mem_wdata", bus.mem_wdata, exp_q[0]);
    end
    chk("count", 32'(count), exp_count);
    chk("full", {31'b0, full}, {31'b0, exp_count == MAX});
    chk("err", {31'b0, err}, {31'b0, exp_err});
    exp_rdy = !rst && !prog_start && (exp_count + exp_q.size() < MAX) &&
              (exp_q.size() == 0 || bus.mem_ready);
    chk("req_ready", {31'b0, bus.req_ready}, {31'b0, exp_rdy});

    if (rst || prog_start) begin
      exp_q.delete();
      exp_addr  = 32'h0;
      exp_count = 0;
      exp_err   = 1'b0;
    end else begin
      if (bus.mem_we && bus.mem_ready && exp_q.size() != 0) begin
        wlog.push_back('{a: bus.mem_addr, d: bus.mem_wdata, c: cyc});
        void'(exp_q.pop_front());
        exp_addr  = exp_addr + 32'd4;
        exp_count = exp_count + 1;
      end
      if (bus.req_valid && bus.req_ready) begin
        if (model_legal(int'(bus.req_op), int'($signed(bus.req_imm))))
          exp_q.push_back(model_word(int'(bus.req_op), int'(bus.req_funct3),
                                     int'(bus.req_sub), int'(bus.req_rd), int'(bus.req_rs1),
                                     int'(bus.req_rs2), int'($signed(bus.req_imm))));
        else
          exp_err = 1'b1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int unsigned op, input int unsigned f3, input bit sub,
                       input int unsigned rd, input int unsigned rs1, input int unsigned rs2,
                       input int imm);
    bus.req_op     = 3'(op);
    bus.req_funct3 = 3'(f3);
    bus.req_sub    = sub;
    bus.req_rd     = 5'(rd);
    bus.req_rs1    = 5'(rs1);
    bus.req_rs2    = 5'(rs2);
    bus.req_imm    = imm;
  endtask

  // Present one request and wait (bounded) until it is accepted
  task automatic send(input int unsigned op, input int unsigned f3, input bit sub,
                      input int unsigned rd, input int unsigned rs1, input int unsigned rs2,
                      input int imm);
    bit accepted;
    accepted = 1'b0;
    drive(op, f3, sub, rd, rs1, rs2, imm);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (bus.req_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    chk("send_accept", {31'b0, accepted}, 32'd1);
  endtask

  task automatic restart();
    prog_start = 1'b1;
    idle(1);
    prog_start = 1'b0;
    wlog.delete();
  endtask

  task automatic chk_wr(input string name, input int idx, input logic [31:0] a,
                        input logic [31:0] d);
    if (wlog.size() > idx) begin
      chk({name, "_addr"}, wlog[idx].a, a);
      chk({name, "_data"}, wlog[idx].d, d);
    end else begin
      chk({name, "_present"}, wlog.size(), idx + 1);
    end
  endtask

  initial begin
    int acc;
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b1;
    drive(0, 0, 1'b0, 0, 0, 0, 0);

    // Reset state
    idle(3);
    @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ADDI x1,x0,5
    wlog.delete();
    send(1, 0, 1'b0, 1, 0, 0, 5);
    idle(2);
    chk("addi_nwr", wlog.size(), 32'd1);
    chk_wr("addi", 0, 32'h0, 32'h0050_0093);
    chk("addi_count", 32'(count), 32'd1);

    // ADD then SUB back to back
    restart();
    send(0, 0, 1'b0, 3, 1, 2, 0);
    send(0, 0, 1'b1, 3, 1, 2, 0);
    idle(2);
    chk_wr("add", 0, 32'h0, 32'h0020_81B3);
    chk_wr("sub", 1, 32'h4, 32'h4020_81B3);
    if (wlog.size() == 2) chk("addsub_b2b", wlog[1].c - wlog[0].c, 32'd1);

    // SW x2,8(x1) then BEQ x1,x2,-4 with a 3-cycle memory stall
    restart();
    send(3, 2, 1'b0, 0, 1, 2, 8);
    send(4, 0, 1'b0, 0, 1, 2, -4);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_we", {31'b0, bus.mem_we}, 32'd1);
      chk("stall_addr", bus.mem_addr, 32'h4);
      chk("stall_wdata", bus.mem_wdata, 32'hFE20_8EE3);
      chk("stall_ready", {31'b0, bus.req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b1;
    idle(2);
    chk_wr("sw", 0, 32'h0, 32'h0020_A423);
    chk_wr("beq", 1, 32'h4, 32'hFE20_8EE3);

    // Illegal op, then ADDI with an out-of-12-bit immediate
    restart();
    send(6, 0, 1'b0, 1, 0, 0, 0);
    @(negedge clk);
    chk("illop_err", {31'b0, err}, 32'd1);
    chk("illop_we", {31'b0, bus.mem_we}, 32'd0);
    chk("illop_addr", bus.mem_addr, 32'h0);
    @(posedge clk);
    #1;
    send(1, 0, 1'b0, 1, 0, 0, 2048);
    idle(2);
`ifdef ENCODER_RANGE_CHECK_EN
    chk("bigimm_nwr", wlog.size(), 32'd0);
    chk("bigimm_addr", bus.mem_addr, 32'h0);
`else
    chk_wr("bigimm", 0, 32'h0, 32'h8000_0093);
`endif
    chk("bigimm_err", {31'b0, err}, 32'd1);
    restart();
    @(negedge clk);
    chk("clr_err", {31'b0, err}, 32'd0);
    @(posedge clk);
    #1;

    // Stream of 6 requests against MAX_INSTRS=4
    acc = 0;
    drive(1, 0, 1'b0, 1, 0, 0, 0);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 12 && acc < 6; i++) begin
      @(negedge clk);
      if (bus.req_ready) acc++;
      @(posedge clk);
      #1;
      bus.req_imm = acc;
    end
    bus.req_valid = 1'b0;
    idle(2);
    chk("full_acc", acc, 32'd4);
    chk("full_nwr", wlog.size(), 32'd4);
    chk_wr("full0", 0, 32'h0, 32'h0000_0093);
    chk_wr("full3", 3, 32'hC, 32'h0030_0093);
    chk("full_flag", {31'b0, full}, 32'd1);
    chk("full_ready", {31'b0, bus.req_ready}, 32'd0);
    restart();
    @(negedge clk);
    chk("restart_addr", bus.mem_addr, 32'h0);
    chk("restart_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;

    // prog_start against a pending write and a valid request
    bus.mem_ready = 1'b0;
    send(1, 0, 1'b0, 2, 0, 0, 7);
    drive(1, 0, 1'b0, 3, 0, 0, 9);
    bus.req_valid = 1'b1;
    bus.mem_ready = 1'b1;
    prog_start    = 1'b1;
    @(negedge clk);
    chk("ps_ready", {31'b0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    prog_start    = 1'b0;
    bus.req_valid = 1'b0;
    wlog.delete();
    @(negedge clk);
    chk("ps_we", {31'b0, bus.mem_we}, 32'd0);
    chk("ps_count", 32'(count), 32'd0);
    idle(2);
    chk("ps_nwr", wlog.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
